// File: rtl/s3_pc_stack_if.sv
// Decoder <-> PC-stack port bundle: op/condition fields in, PC/stack status out.
// Combinational pc_nxt path plus registered pc/sp/flags; no handshake.
// The decoder holds ops for as long as it drives stall.
interface s3_pc_stack_if #(
    parameter int PC_W        = 8,
    parameter int COND_W      = 4,
    parameter int STACK_DEPTH = 4
);
    localparam int SP_W = $clog2(STACK_DEPTH + 1);

    logic              op_jmp;
    logic              op_call;
    logic              op_ret;
    logic [PC_W-1:0]   op_tgt;
    logic              op_cond_inv;
    logic [COND_W-1:0] op_cond_mask;
    logic [COND_W-1:0] op_cond_val;
    logic [COND_W-1:0] a_reg;
    logic              stall;
    logic              err_clr;
    logic [PC_W-1:0]   pc_nxt;
    logic [PC_W-1:0]   pc;
    logic [SP_W-1:0]   sp;
    logic              stack_ovf;
    logic              stack_unf;

    modport master (
        output op_jmp, op_call, op_ret, op_tgt, op_cond_inv, op_cond_mask,
               op_cond_val, a_reg, stall, err_clr,
        input  pc_nxt, pc, sp, stack_ovf, stack_unf
    );

    modport slave (
        input  op_jmp, op_call, op_ret, op_tgt, op_cond_inv, op_cond_mask,
               op_cond_val, a_reg, stall, err_clr,
        output pc_nxt, pc, sp, stack_ovf, stack_unf
    );
endinterface

// File: rtl/s3_pc_stack.sv
// S3 sequencer PC with conditional jump/call/return and a LIFO return stack.
// pc_nxt is zero-latency combinational (feeds sync I-RAM address); pc/sp update at the edge.
// stall freezes pc, sp, stack and sticky flags; nothing is dropped except pushes on a full stack.
module s3_pc_stack #(
    parameter int PC_W        = 8,
    parameter int COND_W      = 4,
    parameter int STACK_DEPTH = 4,
    parameter int RST_PC      = 0
) (
    input  logic         clk,
    input  logic         rst,
    s3_pc_stack_if.slave bus
);
    localparam int SP_W  = $clog2(STACK_DEPTH + 1);
    localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    logic [PC_W-1:0] pc_q;
    logic [SP_W-1:0] sp_q;
    logic            ovf_q;
    logic            unf_q;
    logic [PC_W-1:0] stack_mem [STACK_DEPTH];

    logic            cond_ok;
    logic            ret_tk;
    logic            call_tk;
    logic            jmp_tk;
    logic            stack_full;
    logic            stack_empty;
    logic            push;
    logic            pop;
    logic            ovf_set;
    logic            unf_set;
    logic [PC_W-1:0] inc;
    logic [IDX_W-1:0] top_idx;
    logic [IDX_W-1:0] wr_idx;
    logic [PC_W-1:0] pc_nxt;

    assign cond_ok = ((bus.a_reg & bus.op_cond_mask) == bus.op_cond_val) ^ bus.op_cond_inv;

    // Priority ret > call > jmp keeps push and pop mutually exclusive.
    assign ret_tk  = bus.op_ret & cond_ok;
    assign call_tk = ~bus.op_ret & bus.op_call & cond_ok;
    assign jmp_tk  = ~bus.op_ret & ~bus.op_call & bus.op_jmp & cond_ok;

    assign stack_full  = (sp_q == SP_W'(STACK_DEPTH));
    assign stack_empty = (sp_q == '0);
    assign inc         = pc_q + 1'b1;
    assign top_idx     = IDX_W'(sp_q - 1'b1);
    assign wr_idx      = IDX_W'(sp_q);

    assign push    = ~bus.stall & call_tk & ~stack_full;
    assign pop     = ~bus.stall & ret_tk & ~stack_empty;
    assign ovf_set = ~bus.stall & call_tk & stack_full;
    assign unf_set = ~bus.stall & ret_tk & stack_empty;

    always_comb begin
        pc_nxt = inc;
        if (rst) begin
            pc_nxt = PC_W'(RST_PC);
        end else if (bus.stall) begin
            pc_nxt = pc_q;
        end else if (ret_tk) begin
            pc_nxt = stack_empty ? inc : stack_mem[top_idx];
        end else if (call_tk || jmp_tk) begin
            pc_nxt = bus.op_tgt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q  <= PC_W'(RST_PC);
            sp_q  <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else if (!bus.stall) begin
            pc_q <= pc_nxt;
            if (push) begin
                sp_q <= sp_q + 1'b1;
            end else if (pop) begin
                sp_q <= sp_q - 1'b1;
            end
            // A fresh error in the clearing cycle wins over err_clr.
            ovf_q <= ovf_set | (ovf_q & ~bus.err_clr);
            unf_q <= unf_set | (unf_q & ~bus.err_clr);
        end
    end

    // Return addresses are don't-care after reset, so the array carries no reset.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            stack_mem[wr_idx] <= inc;
        end
    end

    assign bus.pc_nxt    = pc_nxt;
    assign bus.pc        = pc_q;
    assign bus.sp        = sp_q;
    assign bus.stack_ovf = ovf_q;
    assign bus.stack_unf = unf_q;
endmodule

// File: tb/tb_s3_pc_stack.sv
// Directed bench for s3_pc_stack: reset, conditions, call/ret, stack errors, stall, async reset.
module tb_s3_pc_stack;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    s3_pc_stack_if #(.PC_W(8), .COND_W(4), .STACK_DEPTH(4)) bus ();

    s3_pc_stack #(.PC_W(8), .COND_W(4), .STACK_DEPTH(4), .RST_PC(0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Always-true condition: mask=0, val=0, inv=0.
    task automatic set_op(input logic jmp, input logic call, input logic ret, input logic [7:0] tgt);
        bus.op_jmp       = jmp;
        bus.op_call      = call;
        bus.op_ret       = ret;
        bus.op_tgt       = tgt;
        bus.op_cond_inv  = 1'b0;
        bus.op_cond_mask = 4'b0000;
        bus.op_cond_val  = 4'b0000;
        bus.a_reg        = 4'b0110;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic goto(input logic [7:0] addr);
        set_op(1'b1, 1'b0, 1'b0, addr);
        step();
        set_op(1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    logic [7:0] exp_ret [5];
    logic [7:0] from_pc [5];
    logic [7:0] to_pc   [5];

    initial begin
        bus.stall   = 1'b0;
        bus.err_clr = 1'b0;
        set_op(1'b0, 1'b0, 1'b0, 8'h00);
        from_pc = '{8'h01, 8'h21, 8'h41, 8'h61, 8'h81};
        to_pc   = '{8'h20, 8'h40, 8'h60, 8'h80, 8'hA0};
        exp_ret = '{8'h62, 8'h42, 8'h22, 8'h02, 8'h03};

        // 1. reset and increment
        #3;
        chk("rst_pc", bus.pc, 8'h00);
        chk("rst_pc_nxt", bus.pc_nxt, 8'h00);
        chk("rst_sp", bus.sp, 0);
        chk("rst_ovf", bus.stack_ovf, 0);
        chk("rst_unf", bus.stack_unf, 0);
        step();
        chk("rst_hold_pc", bus.pc, 8'h00);
        rst = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            step();
            chk("inc_pc", bus.pc, 32'(i));
        end
        goto(8'hFF);
        chk("pre_ff", bus.pc, 8'hFF);
        #1 chk("wrap_nxt", bus.pc_nxt, 8'h00);
        step();
        chk("wrap_pc", bus.pc, 8'h00);

        // 2. conditional jump
        goto(8'h05);
        bus.a_reg = 4'b1010; bus.op_cond_mask = 4'b1100; bus.op_cond_val = 4'b1000;
        bus.op_cond_inv = 1'b0; bus.op_jmp = 1'b1; bus.op_tgt = 8'h40;
        #1 chk("jmp_taken_nxt", bus.pc_nxt, 8'h40);
        bus.op_cond_inv = 1'b1;
        #1 chk("jmp_inv_nxt", bus.pc_nxt, 8'h06);
        bus.op_cond_inv = 1'b0; bus.op_cond_val = 4'b1010;
        #1 chk("jmp_valbits_nxt", bus.pc_nxt, 8'h06);
        bus.op_cond_val = 4'b1000;
        step();
        chk("jmp_pc", bus.pc, 8'h40);

        // 3. call / return
        goto(8'h10);
        set_op(1'b0, 1'b1, 1'b0, 8'h80);
        step();
        chk("call_pc", bus.pc, 8'h80);
        chk("call_sp", bus.sp, 1);
        set_op(1'b0, 1'b0, 1'b0, 8'h00);
        repeat (5) step();
        chk("idle_pc", bus.pc, 8'h85);
        set_op(1'b0, 1'b0, 1'b1, 8'h00);
        #1 chk("ret_nxt", bus.pc_nxt, 8'h11);
        step();
        chk("ret_pc", bus.pc, 8'h11);
        chk("ret_sp", bus.sp, 0);
        chk("ret_ovf", bus.stack_ovf, 0);
        chk("ret_unf", bus.stack_unf, 0);

        // 4. overflow / underflow
        for (int i = 0; i < 5; i++) begin
            goto(from_pc[i]);
            set_op(1'b0, 1'b1, 1'b0, to_pc[i]);
            step();
            chk("nest_pc", bus.pc, 32'(to_pc[i]));
            chk("nest_sp", bus.sp, (i < 4) ? 32'(i + 1) : 32'd4);
            chk("nest_ovf", bus.stack_ovf, (i == 4) ? 32'd1 : 32'd0);
        end
        set_op(1'b0, 1'b0, 1'b1, 8'h00);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("unwind_pc", bus.pc, 32'(exp_ret[i]));
            chk("unwind_sp", bus.sp, (i < 4) ? 32'(3 - i) : 32'd0);
            chk("unwind_unf", bus.stack_unf, (i == 4) ? 32'd1 : 32'd0);
        end
        chk("ovf_sticky", bus.stack_ovf, 1);
        set_op(1'b0, 1'b0, 1'b0, 8'h00);
        bus.err_clr = 1'b1;
        step();
        bus.err_clr = 1'b0;
        chk("clr_ovf", bus.stack_ovf, 0);
        chk("clr_unf", bus.stack_unf, 0);

        // 5. stall
        goto(8'h07);
        bus.stall = 1'b1;
        set_op(1'b0, 1'b1, 1'b0, 8'h30);
        #1 chk("stall_nxt", bus.pc_nxt, 8'h07);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_pc", bus.pc, 8'h07);
            chk("stall_sp", bus.sp, 0);
            chk("stall_ovf", bus.stack_ovf, 0);
        end
        bus.stall = 1'b0;
        #1 chk("unstall_nxt", bus.pc_nxt, 8'h30);
        step();
        chk("unstall_pc", bus.pc, 8'h30);
        chk("unstall_sp", bus.sp, 1);

        // 6. async reset mid-operation
        set_op(1'b0, 1'b1, 1'b0, 8'h55);
        step();
        chk("pre_rst_pc", bus.pc, 8'h55);
        chk("pre_rst_sp", bus.sp, 2);
        set_op(1'b0, 1'b0, 1'b1, 8'h00);
        #1 rst = 1'b1;
        #1;
        chk("arst_pc", bus.pc, 8'h00);
        chk("arst_nxt", bus.pc_nxt, 8'h00);
        chk("arst_sp", bus.sp, 0);
        chk("arst_unf", bus.stack_unf, 0);
        #1 rst = 1'b0;
        step();
        chk("post_rst_pc", bus.pc, 8'h01);
        chk("post_rst_unf", bus.stack_unf, 1);
        chk("post_rst_sp", bus.sp, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
